// File: rtl/fft4_sched_pkg.sv
// Shared types and constants for the 4-point FFT frame scheduler.
package fft4_sched_pkg;

    localparam int FFT_N      = 4;
    localparam int DATA_W_DEF = 8;
    localparam int BIN_W_DEF  = DATA_W_DEF + 2;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_e;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } sample_t;

    typedef struct packed {
        logic signed [BIN_W_DEF-1:0] re;
        logic signed [BIN_W_DEF-1:0] im;
    } bin_t;

endpackage

// File: rtl/fft4_out_ser.sv
// Holds the four captured FFT bins and streams them out one per handshake.
module fft4_out_ser
    import fft4_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    active,
    input  logic signed [WIDTH-1:0] in_real [FFT_N],
    input  logic signed [WIDTH-1:0] in_imag [FFT_N],
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic        [WIDTH-1:0] m_real,
    output logic        [WIDTH-1:0] m_imag,
    output logic        [1:0]       m_idx,
    output logic                    m_last,
    output logic                    done
);

    logic signed [WIDTH-1:0] re_q [FFT_N];
    logic signed [WIDTH-1:0] im_q [FFT_N];
    logic [1:0]              ptr_q;
    logic                    hs;

    assign hs      = active & m_ready;
    assign done    = hs & (ptr_q == 2'd3);
    assign m_valid = active;
    assign m_real  = re_q[ptr_q];
    assign m_imag  = im_q[ptr_q];
    assign m_idx   = ptr_q;
    assign m_last  = active & (ptr_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < FFT_N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (load) begin
            ptr_q <= '0;
            for (int i = 0; i < FFT_N; i++) begin
                re_q[i] <= in_real[i];
                im_q[i] <= in_imag[i];
            end
        end else if (hs) begin
            // Wraps 3 -> 0 on the final bin, ready for the next frame.
            ptr_q <= ptr_q + 2'd1;
        end
    end

endmodule

// File: rtl/fft4_frame_sched.sv
// Gathers 4-sample frames, launches the fft4 core, captures its bins after a
// fixed latency and drains them serially with backpressure.
module fft4_frame_sched
    import fft4_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CORE_LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_real,
    input  logic [DATA_WIDTH-1:0]   s_imag,
    output logic                    core_rst_n,
    output logic                    core_en,
    output logic [DATA_WIDTH-1:0]   core_in0_real,
    output logic [DATA_WIDTH-1:0]   core_in0_imag,
    output logic [DATA_WIDTH-1:0]   core_in1_real,
    output logic [DATA_WIDTH-1:0]   core_in1_imag,
    output logic [DATA_WIDTH-1:0]   core_in2_real,
    output logic [DATA_WIDTH-1:0]   core_in2_imag,
    output logic [DATA_WIDTH-1:0]   core_in3_real,
    output logic [DATA_WIDTH-1:0]   core_in3_imag,
    input  logic [DATA_WIDTH+1:0]   core_out0_real,
    input  logic [DATA_WIDTH+1:0]   core_out0_imag,
    input  logic [DATA_WIDTH+1:0]   core_out1_real,
    input  logic [DATA_WIDTH+1:0]   core_out1_imag,
    input  logic [DATA_WIDTH+1:0]   core_out2_real,
    input  logic [DATA_WIDTH+1:0]   core_out2_imag,
    input  logic [DATA_WIDTH+1:0]   core_out3_real,
    input  logic [DATA_WIDTH+1:0]   core_out3_imag,
    input  logic                    core_valid,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH+1:0]   m_real,
    output logic [DATA_WIDTH+1:0]   m_imag,
    output logic [1:0]              m_idx,
    output logic                    m_last,
    output logic [15:0]             frame_cnt,
    output logic                    err
);

    localparam int unsigned OW    = DATA_WIDTH + 2;
    localparam int unsigned CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_e                      state_q, state_d;
    logic [2:0]                  fill_q;
    logic signed [DATA_WIDTH-1:0] in_re_q [FFT_N];
    logic signed [DATA_WIDTH-1:0] in_im_q [FFT_N];
    logic signed [DATA_WIDTH-1:0] ld_re_q [FFT_N];
    logic signed [DATA_WIDTH-1:0] ld_im_q [FFT_N];
    logic signed [OW-1:0]        cap_re [FFT_N];
    logic signed [OW-1:0]        cap_im [FFT_N];
    logic [CNT_W-1:0]            cnt_q;
    logic                        err_q;
    logic [15:0]                 frame_cnt_q;
    logic                        core_rst_n_q;
    logic                        s_hs, copy, capture, drop, drain, done;

    assign s_ready = (fill_q < 3'(FFT_N));
    assign s_hs    = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_q == 3'(FFT_N)) state_d = LOAD;
            LOAD:    state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = core_valid ? DRAIN : IDLE;
            DRAIN:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        copy    = 1'b0;
        core_en = 1'b0;
        capture = 1'b0;
        drop    = 1'b0;
        drain   = 1'b0;
        case (state_q)
            IDLE:  copy    = (fill_q == 3'(FFT_N));
            LOAD:  core_en = 1'b1;
            WAIT: begin
                capture = (cnt_q == '0) & core_valid;
                drop    = (cnt_q == '0) & ~core_valid;
            end
            DRAIN: drain   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        core_rst_n_q <= ~rst;
        if (rst) begin
            fill_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            for (int i = 0; i < FFT_N; i++) begin
                in_re_q[i] <= '0;
                in_im_q[i] <= '0;
                ld_re_q[i] <= '0;
                ld_im_q[i] <= '0;
            end
        end else begin
            // s_ready is low while fill == 4, so a handshake never meets a copy.
            if (s_hs) begin
                in_re_q[fill_q[1:0]] <= s_real;
                in_im_q[fill_q[1:0]] <= s_imag;
                fill_q               <= fill_q + 3'd1;
            end
            if (copy) begin
                fill_q <= '0;
                for (int i = 0; i < FFT_N; i++) begin
                    ld_re_q[i] <= in_re_q[i];
                    ld_im_q[i] <= in_im_q[i];
                end
            end
            if (core_en)              cnt_q <= CNT_W'(CORE_LAT - 1);
            else if (state_q == WAIT) cnt_q <= cnt_q - CNT_W'(1);
            if (drop) err_q <= 1'b1;
            if (done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign core_rst_n    = core_rst_n_q;
    assign err           = err_q;
    assign frame_cnt     = frame_cnt_q;
    assign core_in0_real = ld_re_q[0];
    assign core_in0_imag = ld_im_q[0];
    assign core_in1_real = ld_re_q[1];
    assign core_in1_imag = ld_im_q[1];
    assign core_in2_real = ld_re_q[2];
    assign core_in2_imag = ld_im_q[2];
    assign core_in3_real = ld_re_q[3];
    assign core_in3_imag = ld_im_q[3];
    assign cap_re[0]     = core_out0_real;
    assign cap_im[0]     = core_out0_imag;
    assign cap_re[1]     = core_out1_real;
    assign cap_im[1]     = core_out1_imag;
    assign cap_re[2]     = core_out2_real;
    assign cap_im[2]     = core_out2_imag;
    assign cap_re[3]     = core_out3_real;
    assign cap_im[3]     = core_out3_imag;

    fft4_out_ser #(
        .WIDTH(OW)
    ) u_out_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (capture),
        .active  (drain),
        .in_real (cap_re),
        .in_imag (cap_im),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_real  (m_real),
        .m_imag  (m_imag),
        .m_idx   (m_idx),
        .m_last  (m_last),
        .done    (done)
    );

endmodule

// File: tb/tb_fft4_frame_sched.sv
// Scoreboard bench for fft4_frame_sched with a behavioural fft4 core model.
module tb_fft4_frame_sched;
    import fft4_sched_pkg::*;

    localparam int DW  = 8;
    localparam int OW  = DW + 2;
    localparam int LAT = 2;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_real = '0;
    logic [DW-1:0] s_imag = '0;
    logic          core_rst_n, core_en, core_valid;
    logic [DW-1:0] core_in0_real, core_in0_imag, core_in1_real, core_in1_imag;
    logic [DW-1:0] core_in2_real, core_in2_imag, core_in3_real, core_in3_imag;
    logic [OW-1:0] core_out0_real, core_out0_imag, core_out1_real, core_out1_imag;
    logic [OW-1:0] core_out2_real, core_out2_imag, core_out3_real, core_out3_imag;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [OW-1:0] m_real, m_imag;
    logic [1:0]    m_idx;
    logic          m_last;
    logic [15:0]   frame_cnt;
    logic          err;

    int      n_tests = 0;
    int      n_fails = 0;
    exp_t    exp_q[$];
    sample_t fr [4];
    int      en_cnt = 0;
    int      mv_cnt = 0;
    logic    force_bad = 1'b0;

    fft4_frame_sched #(
        .DATA_WIDTH(DW),
        .CORE_LAT  (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_real        (s_real),
        .s_imag        (s_imag),
        .core_rst_n    (core_rst_n),
        .core_en       (core_en),
        .core_in0_real (core_in0_real),
        .core_in0_imag (core_in0_imag),
        .core_in1_real (core_in1_real),
        .core_in1_imag (core_in1_imag),
        .core_in2_real (core_in2_real),
        .core_in2_imag (core_in2_imag),
        .core_in3_real (core_in3_real),
        .core_in3_imag (core_in3_imag),
        .core_out0_real(core_out0_real),
        .core_out0_imag(core_out0_imag),
        .core_out1_real(core_out1_real),
        .core_out1_imag(core_out1_imag),
        .core_out2_real(core_out2_real),
        .core_out2_imag(core_out2_imag),
        .core_out3_real(core_out3_real),
        .core_out3_imag(core_out3_imag),
        .core_valid    (core_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_real        (m_real),
        .m_imag        (m_imag),
        .m_idx         (m_idx),
        .m_last        (m_last),
        .frame_cnt     (frame_cnt),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // 4-point DFT; x packs {in3_im, in3_re, ..., in0_im, in0_re}.
    function automatic logic [8*OW-1:0] fft_pack(input logic [8*DW-1:0] x);
        int xr[4], xi[4], br[4], bi[4];
        logic [8*OW-1:0] r;
        for (int k = 0; k < 4; k++) begin
            xr[k] = int'($signed(x[2*DW*k +: DW]));
            xi[k] = int'($signed(x[2*DW*k+DW +: DW]));
        end
        br[0] = xr[0] + xr[1] + xr[2] + xr[3];
        bi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        br[1] = (xr[0] - xr[2]) + (xi[1] - xi[3]);
        bi[1] = (xi[0] - xi[2]) - (xr[1] - xr[3]);
        br[2] = xr[0] - xr[1] + xr[2] - xr[3];
        bi[2] = xi[0] - xi[1] + xi[2] - xi[3];
        br[3] = (xr[0] - xr[2]) - (xi[1] - xi[3]);
        bi[3] = (xi[0] - xi[2]) + (xr[1] - xr[3]);
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[2*OW*k +: OW]    = OW'(br[k]);
            r[2*OW*k+OW +: OW] = OW'(bi[k]);
        end
        return r;
    endfunction

    // Core model: en sampled at an edge, result and valid appear LAT edges on.
    logic [LAT-1:0]  pv = '0;
    logic [8*OW-1:0] pd [LAT];

    always @(posedge clk) begin
        if (!core_rst_n) begin
            pv <= '0;
        end else begin
            pv[0] <= core_en;
            if (core_en)
                pd[0] <= fft_pack({core_in3_imag, core_in3_real, core_in2_imag, core_in2_real,
                                   core_in1_imag, core_in1_real, core_in0_imag, core_in0_real});
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign core_valid     = pv[LAT-1] & ~force_bad;
    assign core_out0_real = pd[LAT-1][0*OW +: OW];
    assign core_out0_imag = pd[LAT-1][1*OW +: OW];
    assign core_out1_real = pd[LAT-1][2*OW +: OW];
    assign core_out1_imag = pd[LAT-1][3*OW +: OW];
    assign core_out2_real = pd[LAT-1][4*OW +: OW];
    assign core_out2_imag = pd[LAT-1][5*OW +: OW];
    assign core_out3_real = pd[LAT-1][6*OW +: OW];
    assign core_out3_imag = pd[LAT-1][7*OW +: OW];

    logic          hold_q = 1'b0;
    logic [OW-1:0] h_re, h_im;
    logic [1:0]    h_idx;
    logic          h_last;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            if (core_en) en_cnt <= en_cnt + 1;
            if (m_valid) mv_cnt <= mv_cnt + 1;
            if (hold_q && m_valid) begin
                check("hold_real", int'(m_real), int'(h_re));
                check("hold_imag", int'(m_imag), int'(h_im));
                check("hold_idx", int'(m_idx), int'(h_idx));
                check("hold_last", int'(m_last), int'(h_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("bin_unexpected_qsize", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("bin_real", int'($signed(m_real)), e.re);
                    check("bin_imag", int'($signed(m_imag)), e.im);
                    check("bin_idx", int'(m_idx), e.idx);
                    check("bin_last", int'(m_last), e.last);
                end
            end
            hold_q <= m_valid & ~m_ready;
            h_re   <= m_real;
            h_im   <= m_imag;
            h_idx  <= m_idx;
            h_last <= m_last;
        end
    end

    task automatic push_frame();
        logic [8*DW-1:0] x;
        logic [8*OW-1:0] b;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            x[2*DW*k +: DW]    = fr[k].re;
            x[2*DW*k+DW +: DW] = fr[k].im;
        end
        b = fft_pack(x);
        for (int k = 0; k < 4; k++) begin
            e.re   = int'($signed(b[2*OW*k +: OW]));
            e.im   = int'($signed(b[2*OW*k+OW +: OW]));
            e.idx  = k;
            e.last = (k == 3) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int n = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input bit push);
        if (push) push_frame();
        for (int k = 0; k < 4; k++) send_sample(fr[k].re, fr[k].im);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 4; k++) begin
            fr[k].re = DW'($urandom);
            fr[k].im = DW'($urandom);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt != 16'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_cnt", int'(frame_cnt), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        m_ready = 1'b1;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_core_rst_n", int'(core_rst_n), 0);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_core_en", int'(core_en), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_idx", int'(m_idx), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        check("core_rst_n_release", int'(core_rst_n), 1);
        repeat (10) @(negedge clk);
        check("idle_no_en", en_cnt, 0);
        check("idle_m_valid", int'(m_valid), 0);

        // Known frame with constant expected bins
        @(posedge clk);
        #1;
        fr[0].re = 8'sd1;  fr[0].im = 8'sd0;
        fr[1].re = 8'sd2;  fr[1].im = 8'sd0;
        fr[2].re = -8'sd1; fr[2].im = 8'sd0;
        fr[3].re = 8'sd3;  fr[3].im = 8'sd0;
        exp_q.push_back('{re: 5,  im: 0,  idx: 0, last: 0});
        exp_q.push_back('{re: 2,  im: 1,  idx: 1, last: 0});
        exp_q.push_back('{re: -5, im: 0,  idx: 2, last: 0});
        exp_q.push_back('{re: 2,  im: -1, idx: 3, last: 1});
        send_frame(1'b0);
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_bin_latency", n, 3 + LAT);
        wait_frames(1, 50);
        check("single_en_pulse", en_cnt, 1);
        check("known_drained", exp_q.size(), 0);

        // Three back-to-back random frames
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(1'b1);
        end
        wait_frames(4, 100);
        check("b2b_err", int'(err), 0);
        check("b2b_drained", exp_q.size(), 0);

        // Backpressure mid-drain while the next frame fills
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b1);
        n = 0;
        while (!(m_valid && m_idx == 2'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        rand_frame();
        send_frame(1'b1);
        @(negedge clk);
        check("stall_s_ready_full", int'(s_ready), 0);
        check("stall_m_valid", int'(m_valid), 1);
        check("stall_m_idx", int'(m_idx), 1);
        repeat (5) @(negedge clk);
        check("stall_s_ready_held", int'(s_ready), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_frames(6, 100);
        check("stall_drained", exp_q.size(), 0);

        // Core never asserts valid: frame dropped, err sticky
        force_bad = 1'b1;
        base = mv_cnt;
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b0);
        n = 0;
        while (!err && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("err_latency", n, 3 + LAT);
        check("err_set", int'(err), 1);
        repeat (5) @(negedge clk);
        check("err_no_m_valid", mv_cnt - base, 0);
        check("err_frame_cnt", int'(frame_cnt), 6);
        force_bad = 1'b0;
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b1);
        wait_frames(7, 60);
        check("err_sticky", int'(err), 1);

        // Reset while in WAIT with a partial next frame buffered
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b0);
        send_sample(DW'($urandom), DW'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("wrst_m_valid", int'(m_valid), 0);
        check("wrst_err", int'(err), 0);
        check("wrst_s_ready", int'(s_ready), 1);
        check("wrst_frame_cnt", int'(frame_cnt), 0);
        check("wrst_m_idx", int'(m_idx), 0);
        @(posedge clk);
        #1;
        rand_frame();
        send_frame(1'b1);
        wait_frames(1, 60);
        check("wrst_drained", exp_q.size(), 0);
        check("wrst_err_after", int'(err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/fft4_frame_sched.md
# fft4_frame_sched

Frame scheduler that sequences the 4-point FFT core (`fft4`) from streaming inputs. It accepts complex samples one per handshake and gathers them into a 4-sample frame. It launches the core with a one-cycle enable pulse, captures the core's four outputs after a fixed latency, and streams them out serially with backpressure. It sits between the sample source and the downstream consumer, and drives all `fft4` input ports.

## Interface
- `DATA_WIDTH`, 8: input sample component width (signed).
- `CORE_LAT`, 2: cycles from the core enable pulse to the cycle in which core outputs and `core_valid` are sampled; must be ≥1.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input sample ready.
- `s_real`, `s_imag` in DATA_WIDTH: input sample, signed.
- `core_rst_n` out 1: to `fft4.rst_n`; equals `~rst`, registered.
- `core_en` out 1: to `fft4.en`; one-cycle launch pulse.
- `core_in{0..3}_real/imag` out DATA_WIDTH: to `fft4` inputs, held from the launch register.
- `core_out{0..3}_real/imag` in DATA_WIDTH+2: from `fft4` outputs.
- `core_valid` in 1: from `fft4.valid`.
- `m_valid` out 1: output bin valid.
- `m_ready` in 1: output bin ready.
- `m_real`, `m_imag` out DATA_WIDTH+2: output bin, signed.
- `m_idx` out 2: bin index 0..3.
- `m_last` out 1: high with bin 3.
- `frame_cnt` out 16: frames fully drained; wraps at 2^16.
- `err` out 1: sticky; set when `core_valid` is low at a capture cycle.

## Operation
- Input buffer: 4 entries plus a fill count 0..4.
  - `s_ready` = (fill < 4). A handshake writes entry[fill] and increments fill.
  - Samples are accepted in every FSM state.
- FSM states: IDLE, LOAD, WAIT, DRAIN.
  - IDLE: if fill == 4, copy entries 0..3 to the launch register, set fill to 0, and go to LOAD.
  - LOAD: `core_en` = 1 for this cycle only. Load the wait counter with CORE_LAT−1 and go to WAIT.
  - WAIT: decrement the counter. In the cycle the counter equals 0:
    - if `core_valid` = 1, capture all `core_out*` into the output buffer, set bin pointer to 0, go to DRAIN;
    - otherwise set `err` and go to IDLE (frame dropped, `frame_cnt` unchanged).
  - DRAIN: `m_valid` = 1. `m_*` presents output buffer[ptr], `m_idx` = ptr, `m_last` = (ptr == 3).
    - On an `m_valid & m_ready` handshake, ptr increments.
    - On the handshake with ptr == 3: go to IDLE and increment `frame_cnt`.
- Launch register contents stay stable from the copy until the next copy. `core_in*` never changes during WAIT.
- No arithmetic is done in the scheduler; output width is the core width DATA_WIDTH+2, passed through unchanged.
- `err` clears only on `rst`.

## Timing
- Reset values:
  - `s_ready` = 1, `core_en` = 0, `core_rst_n` = 0 (first cycle after release: 1).
  - `m_valid` = 0, `m_idx` = 0, `m_last` = 0.
  - `frame_cnt` = 0, `err` = 0, fill = 0, state IDLE.
  - Data registers = 0.
- Latency: the 4th input handshake is at edge t.
  - IDLE copy at edge t+1.
  - `core_en` high during cycle t+1..t+2.
  - Capture at the end of WAIT: exactly 2+CORE_LAT cycles after the 4th input handshake.
  - First `m_valid` one cycle later.
- Throughput: the next frame can fill during LOAD, WAIT, and DRAIN. With `m_ready` held at 1, the frame period is 4 cycles (fill-bound) or CORE_LAT+6 cycles, whichever is larger.
- `s_ready` falls in the cycle after fill reaches 4. It rises the cycle after the IDLE copy.
- An input handshake and the IDLE copy are never in the same cycle, because `s_ready` = 0 whenever fill == 4.
- `m_valid` holds, with `m_*` stable, while `m_ready` = 0.
- `rst` mid-frame discards the input buffer, launch register, and output buffer. The FSM returns to IDLE on the next edge.

## Structure
- Package `fft4_sched_pkg`:
  - state enum {IDLE, LOAD, WAIT, DRAIN};
  - typedef for a complex sample at DATA_WIDTH and at DATA_WIDTH+2;
  - `FFT_N` = 4.
- One natural sub-module: `fft4_out_ser`. It holds the 4-bin output buffer, ptr, and the `m_*` handshake, and reports a done pulse on the final handshake.
- The `fft4` core is instantiated outside, beside this block.

## Test plan
- Reset, then idle with no input → all outputs at their reset values; `core_en` never pulses.
- Input (1,0),(2,0),(−1,0),(3,0) with the real `fft4`, `m_ready` = 1 → bins (5,0),(2,1),(−5,0),(2,−1) with idx 0..3; `m_last` on bin 3; `frame_cnt` = 1; `core_en` high exactly one cycle.
- Three back-to-back frames, `s_valid` and `m_ready` always 1 → 12 bins in order, `frame_cnt` = 3, `err` = 0, no input stall beyond fill-full.
- `m_ready` low for 10 cycles mid-DRAIN → `m_*` stable. Meanwhile the next 4 samples are accepted, then `s_ready` = 0 until the IDLE copy.
- Core model with `core_valid` forced low → `err` = 1 at the capture cycle, no `m_valid`, `frame_cnt` unchanged, next frame processed normally.
- `rst` asserted during WAIT → state IDLE, fill 0, `m_valid` 0, `err` 0 on the next edge. A subsequent frame produces correct bins.
